// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: N-byte add built by stepping one external 8-bit adder LSB-first.
// Optional subtract mode (A-B via ~B and carry-in 1) is enabled by defining SUBTRACT_EN.
module multibyte_add_seq #(
  parameter int NBYTES = 4,
  localparam int W  = 8 * NBYTES,
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
`ifdef SUBTRACT_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ov,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout,
  input  logic         add_ov,
  output logic [1:0]   dbg_state
);

  // Handshake: start is taken only on an edge where the FSM is IDLE; busy covers RUN and
  // DONE, and done pulses for one cycle when result/cout/ov become valid (held until next start).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_r, b_r;
  logic [IW-1:0]  idx_q;
  logic           carry_q;
  logic           last_byte;
  logic [W-1:0]   b_load;
  logic           carry_load;

  assign last_byte = (idx_q == IW'(NBYTES - 1));
  assign dbg_state = state_q;

`ifdef SUBTRACT_EN
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy    = 1'b1;
        add_a   = a_r[{idx_q, 3'b000} +: 8];
        add_b   = b_r[{idx_q, 3'b000} +: 8];
        add_cin = carry_q;
        if (last_byte) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: one sum byte per RUN cycle; only the MSB byte's cout/ov reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ov      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_r     <= op_a;
            b_r     <= b_load;
            carry_q <= carry_load;
            idx_q   <= '0;
            result  <= '0;
          end
        end
        RUN: begin
          result[{idx_q, 3'b000} +: 8] <= add_sum;
          carry_q <= add_cout;
          if (last_byte) begin
            cout <= add_cout;
            ov   <= add_ov;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq (NBYTES=4) with a behavioural add8bit beside it.
// Define SUBTRACT_EN to build and check the subtract path as well.
module tb_multibyte_add_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk, rst_n, start, cin, sub;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done, cout, ov;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout, add_ov;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout), .ov(ov),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ov(add_ov), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural 8-bit adder
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    add_ov = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   sum;
    logic         v;
    bb  = s ? ~b : b;
    cc  = s ? 1'b1 : c;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    v   = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return {sum[W], v, sum[W-1:0]};
  endfunction

  // wait for done (bounded), check latency counted from the accepting edge, pop and compare
  task automatic wait_and_score(input string tag);
    int lat;
    logic [W+1:0] e;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, lat, NB);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_result"}, result, e[W-1:0]);
    check({tag, "_ov"}, ov, e[W]);
    check({tag, "_cout"}, cout, e[W+1]);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_held"}, result, e[W-1:0]);
  endtask

  // driver: assumes the DUT is IDLE at the next edge
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    exp_q.push_back(model(a, b, c, s));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_add_a0"}, add_a, a[7:0]);
    check({tag, "_add_b0"}, add_b, bb[7:0]);
    check({tag, "_add_cin0"}, add_cin, s ? 1'b1 : c);
    wait_and_score(tag);
  endtask

  initial begin
    start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ov", ov, 1'b0);
    check("rst_add_a", add_a, 8'h00);
    check("rst_add_cin", add_cin, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    do_op("t1", 32'h0000_00A5, 32'h0000_005A, 1'b0, 1'b0);
    do_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("t3b", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);

    // start held through RUN with changed operands: ignored until the first IDLE cycle
    @(negedge clk);
    start = 1'b1; op_a = 32'h0000_1234; op_b = 32'h0000_1111; cin = 1'b0;
    exp_q.push_back(model(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0));
    @(posedge clk); #1;
    op_a = 32'h0F00_0000; op_b = 32'h0100_0000;
    begin
      int lat;
      logic [W+1:0] e;
      lat = 0;
      while (lat < 20) begin
        @(posedge clk); #1;
        lat++;
        if (done) break;
      end
      check("t4_done", done, 1'b1);
      check("t4_latency", lat, NB);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("t4_first_result", result, e[W-1:0]);
      exp_q.push_back(model(32'h0F00_0000, 32'h0100_0000, 1'b0, 1'b0));
      @(posedge clk); #1;
      check("t4_idle_no_done", done, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      check("t4_second_accepted", busy, 1'b1);
      wait_and_score("t4b");
    end

    // reset in RUN at idx=2
    @(negedge clk);
    start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h1111_1111; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_result", result, '0);
    check("t5_done", done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      check("t5_no_done", seen, 1'b0);
    end
    do_op("t5b", 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)} & 32'hFFFF_FFFF;
      rb = $urandom_range(0, 32'hFFFF_FFFF);
      do_op("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef SUBTRACT_EN
    do_op("t6a", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    do_op("t6b", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
    do_op("t6c", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
